hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage in-order pipeline. It drives the stall/flush

---
 rtl/hazard_ctrl.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs are combinational from inputs and state.
// Optional perf counters are enabled by HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
`ifdef HAZARD_CTRL_PERF_EN
  ,
  parameter int CNT_W = 32
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ireq_busy,
  input  logic             dreq_busy,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_redirect,
  input  logic [XLEN-1:0]  ex_redirect_pc,
  output logic             handshake_stall,
  output logic             if_stall,
  output logic             if_bubble,
  output logic             load_stall,
  output logic             jump_flag,
  output logic             redir_valid,
  output logic [XLEN-1:0]  redir_pc,
  output logic             pend
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  typedef enum logic {RUN, REDIR_PEND} state_t;

  state_t          state, nxt_state;
  logic [XLEN-1:0] pend_pc, nxt_pend_pc;
  logic            hazard;

  assign hazard = ex_is_load && (ex_rd != '0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    handshake_stall = 1'b0;
    if_stall        = 1'b0;
    if_bubble       = 1'b0;
    load_stall      = 1'b0;
    jump_flag       = 1'b0;
    redir_valid     = 1'b0;
    redir_pc        = '0;
    nxt_state       = state;
    nxt_pend_pc     = pend_pc;
    if (reset) begin
      nxt_state = RUN;
    end else if (dreq_busy) begin
      // Whole pipe frozen; EX-stage requests are seen again next cycle.
      handshake_stall = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_redirect) begin
            jump_flag = 1'b1;
            if (!ireq_busy) begin
              redir_valid = 1'b1;
              redir_pc    = ex_redirect_pc;
            end else begin
              if_stall    = 1'b1;
              nxt_pend_pc = ex_redirect_pc;
              nxt_state   = REDIR_PEND;
            end
          end else if (hazard) begin
            load_stall = 1'b1;
            if_stall   = 1'b1;
          end else if (ireq_busy) begin
            if_stall  = 1'b1;
            if_bubble = 1'b1;
          end
        end
        REDIR_PEND: begin
          // Everything fetched while parked is wrong-path; newest redirect wins.
          if_bubble = 1'b1;
          if (ex_redirect) begin
            jump_flag   = 1'b1;
            nxt_pend_pc = ex_redirect_pc;
          end
          if (ireq_busy) begin
            if_stall = 1'b1;
          end else begin
            redir_valid = 1'b1;
            redir_pc    = ex_redirect ? ex_redirect_pc : pend_pc;
            nxt_state   = RUN;
          end
        end
        default: nxt_state = RUN;
      endcase
    end
  end

  assign pend = !reset && (state == REDIR_PEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= RUN;
      pend_pc <= '0;
    end else begin
      state   <= nxt_state;
      pend_pc <= nxt_pend_pc;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (handshake_stall || load_stall || if_stall)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (jump_flag)
        flush_count <= flush_count + CNT_W'(1);
    end
  end
`endif

endmodule
